// File: rtl/sound_pkg.sv
// Shared types and constants for the sound sequencer: FSM state encoding,
// sound index constants, default play lengths and small mask helpers.
// No ports; imported by sound_arbiter_seq.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } snd_state_e;

  localparam logic [1:0] SND_SHOT  = 2'd0;
  localparam logic [1:0] SND_MARCH = 2'd1;
  localparam logic [1:0] SND_UFO   = 2'd2;
  localparam logic [1:0] SND_EXPL  = 2'd3;

  // Default play lengths in sound ticks
  localparam int DUR_SHOT_DEF  = 4;
  localparam int DUR_MARCH_DEF = 2;
  localparam int DUR_UFO_DEF   = 8;
  localparam int DUR_EXPL_DEF  = 16;

  function automatic logic [3:0] snd_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  // Sounds that outrank sel (strictly higher index)
  function automatic logic [3:0] snd_above_mask(input logic [1:0] sel);
    logic [3:0] m;
    case (sel)
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sound_tick_prescaler.sv
// Free-running divider producing the slow sound tick.
// Ports: CLK, Rst (sync, active-high) in; tick out, high one cycle in every TICK_DIV.
// Latency: tick is a decode of the count register; no backpressure.
module sound_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLK,
  input  logic Rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/sound_arbiter_seq.sv
// Shares one tone generator among shot/march/UFO/explosion: latches request
// pulses, grants by fixed priority (index 3 highest), times each sound in
// slow ticks and inserts a silent gap afterwards.
// Ports: CLK, Rst (sync, active-high), req[3:0] pulses, mute in;
//        tone_sel, tone_en, grant (one-hot), busy, done (pulse), pending out.
// Latency: request in IDLE -> tone_en two cycles later (IDLE->LOAD->PLAY).
// Build option: SND_PREEMPT_EN lets a higher-index pending sound abort PLAY.
module sound_arbiter_seq
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int DUR_W     = 8,
  parameter int DUR0      = DUR_SHOT_DEF,
  parameter int DUR1      = DUR_MARCH_DEF,
  parameter int DUR2      = DUR_UFO_DEF,
  parameter int DUR3      = DUR_EXPL_DEF,
  parameter int GAP_TICKS = 1
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [1:0] tone_sel,
  output logic       tone_en,
  output logic [3:0] grant,
  output logic       busy,
  output logic       done,
  output logic [3:0] pending
);

  logic tick;

  sound_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .CLK (CLK),
    .Rst (Rst),
    .tick(tick)
  );

  snd_state_e       state_q;
  logic [1:0]       sel_q;
  logic [3:0]       pend_q, pend_d;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] gap_q;

  // Requests arriving this cycle already count, so IDLE reacts without an
  // extra cycle of delay through the pending register.
  logic [3:0] pend_set;
  assign pend_set = pend_q | req;

  logic [1:0] pick;
  always_comb begin
    pick = SND_SHOT;
    if (pend_q[3])      pick = SND_EXPL;
    else if (pend_q[2]) pick = SND_UFO;
    else if (pend_q[1]) pick = SND_MARCH;
  end

  logic [DUR_W-1:0] dur_raw, dur_load;
  always_comb begin
    dur_raw = DUR_W'(DUR0);
    case (pick)
      SND_MARCH: dur_raw = DUR_W'(DUR1);
      SND_UFO:   dur_raw = DUR_W'(DUR2);
      SND_EXPL:  dur_raw = DUR_W'(DUR3);
      default:   dur_raw = DUR_W'(DUR0);
    endcase
    // A zero-length sound still plays for one tick
    dur_load = (dur_raw == '0) ? DUR_W'(1) : dur_raw;
  end

  logic preempt;
`ifdef SND_PREEMPT_EN
  assign preempt = (state_q == PLAY) && |(pend_set & snd_above_mask(sel_q));
`else
  assign preempt = 1'b0;
`endif

  // Set wins over the LOAD-time clear, so a coincident request re-queues.
  assign pend_d = ((state_q == LOAD) ? (pend_q & ~snd_onehot(pick)) : pend_q) | req;

  logic play_end;
  assign play_end = (state_q == PLAY) && tick && (dur_q == DUR_W'(1)) && !preempt;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pend_q  <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (|pend_set) state_q <= LOAD;
        end
        LOAD: begin
          sel_q   <= pick;
          dur_q   <= dur_load;
          state_q <= PLAY;
        end
        PLAY: begin
          if (preempt) begin
            state_q <= LOAD;
          end else if (tick) begin
            if (dur_q == DUR_W'(1)) begin
              gap_q   <= DUR_W'(GAP_TICKS);
              state_q <= (GAP_TICKS == 0) ? IDLE : GAP;
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            gap_q <= gap_q - DUR_W'(1);
            if (gap_q < DUR_W'(2)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tone_sel = sel_q;
  assign busy     = (state_q != IDLE);
  assign grant    = (state_q == PLAY) ? snd_onehot(sel_q) : 4'b0000;
  assign tone_en  = (state_q == PLAY) && !mute;
  // Suppressed under reset so an aborted sound never reports completion
  assign done     = play_end && !Rst;
  assign pending  = pend_q;

endmodule
